// File: rtl/rm_violation_reporter_if.sv
// Report stream between the violation reporter and the CSR/trace/interrupt logic.
//   valid : report available (driven by master)
//   ready : consumer accepts the report (driven by slave)
//   rule  : index of the reported rule
//   ts    : free-running timestamp captured when the report was loaded
//   ovf   : the rule re-fired while already pending before this report
interface rm_violation_reporter_if #(
  parameter int NUM_RULES = 78,
  parameter int TS_W      = 32
);
  localparam int ID_W = $clog2(NUM_RULES);

  logic            valid;
  logic            ready;
  logic [ID_W-1:0] rule;
  logic [TS_W-1:0] ts;
  logic            ovf;

  modport master (output valid, rule, ts, ovf, input ready);
  modport slave  (input valid, rule, ts, ovf, output ready);
endinterface

// File: rtl/rm_violation_reporter.sv
// Runtime-monitor violation reporter.
// Detects rising edges on the per-rule monitor flags, keeps them as sticky
// pending events and serialises them lowest-index-first onto a valid/ready
// report stream with a timestamp and an overrun flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   monitor_i     : rule flags from the monitor lane
//   monitor_en_i  : 1 = flags valid, 0 = ignore edges
//   mask_i        : per-rule enable for new events
//   clear_i       : synchronous flush of pending, overrun, report, drop counter
//   report        : report stream (master side)
//   irq_o         : level interrupt, report valid or anything pending
//   drop_cnt_o    : saturating count of overrun events
module rm_violation_reporter #(
  parameter int NUM_RULES = 78,
  parameter int TS_W      = 32,
  parameter int DROP_W    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_RULES-1:0]          monitor_i,
  input  logic                          monitor_en_i,
  input  logic [NUM_RULES-1:0]          mask_i,
  input  logic                          clear_i,
  rm_violation_reporter_if.master       report,
  output logic                          irq_o,
  output logic [DROP_W-1:0]             drop_cnt_o
);
  localparam int ID_W  = $clog2(NUM_RULES);
  // Wide enough to add up to NUM_RULES overruns in one cycle without wrapping.
  localparam int SUM_W = DROP_W + ID_W + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_n;
  logic [NUM_RULES-1:0] prev_q, pending_q, ovf_q;
  logic [NUM_RULES-1:0] pending_n, ovf_n, rise, overrun, load_clr;
  logic [TS_W-1:0]      ts_cnt_q;
  logic [DROP_W-1:0]    drop_q, drop_n;
  logic [SUM_W-1:0]     drop_sum;
  logic [ID_W-1:0]      sel_idx, rule_q;
  logic [TS_W-1:0]      ts_q;
  logic                 rovf_q, irq_q;
  logic                 load;

  assign rise = monitor_i & ~prev_q & mask_i & {NUM_RULES{monitor_en_i}};

  // Lowest set pending index wins; scanning downward leaves the lowest one.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = ID_W'(i);
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state_q;
    load     = 1'b0;
    load_clr = '0;
    case (state_q)
      IDLE: if (pending_q != '0) begin
        load              = 1'b1;
        load_clr[sel_idx] = 1'b1;
        state_n           = SEND;
      end
      SEND: if (report.ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear_i) begin
      state_n = IDLE;
      load    = 1'b0;
    end
  end

  // A rise on a rule that is being loaded this cycle is a fresh event, not an overrun.
  assign overrun  = rise & pending_q & ~load_clr;
  assign drop_sum = SUM_W'(drop_q) + SUM_W'($countones(overrun));

  always_comb begin
    pending_n = rise | (pending_q & ~load_clr);
    ovf_n     = (ovf_q & ~load_clr) | overrun;
    drop_n    = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
    if (clear_i) begin
      pending_n = '0;
      ovf_n     = '0;
      drop_n    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      ts_cnt_q  <= '0;
      drop_q    <= '0;
      rule_q    <= '0;
      ts_q      <= '0;
      rovf_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      prev_q    <= monitor_i;
      pending_q <= pending_n;
      ovf_q     <= ovf_n;
      ts_cnt_q  <= ts_cnt_q + 1'b1;
      drop_q    <= drop_n;
      irq_q     <= (state_n == SEND) | (pending_n != '0);
      if (load) begin
        rule_q <= sel_idx;
        ts_q   <= ts_cnt_q;
        rovf_q <= ovf_q[sel_idx];
      end
    end
  end

  // valid decodes straight from the state register so an asynchronous reset
  // drops it immediately.
  assign report.valid = (state_q == SEND);
  assign report.rule  = rule_q;
  assign report.ts    = ts_q;
  assign report.ovf   = rovf_q;
  assign irq_o        = irq_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_rm_violation_reporter.sv
module tb_rm_violation_reporter;
  localparam int NUM_RULES = 78;
  localparam int TS_W      = 32;
  localparam int DROP_W    = 16;
  localparam int ID_W      = $clog2(NUM_RULES);
  localparam int DROP_MAX  = (1 << DROP_W) - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NUM_RULES-1:0] mon, mask;
  logic                 en, clear, ready;
  logic                 irq;
  logic [DROP_W-1:0]    drop;

  rm_violation_reporter_if #(.NUM_RULES(NUM_RULES), .TS_W(TS_W)) rpt ();
  assign rpt.ready = ready;

  rm_violation_reporter #(.NUM_RULES(NUM_RULES), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .monitor_i(mon), .monitor_en_i(en),
    .mask_i(mask), .clear_i(clear), .report(rpt.master), .irq_o(irq), .drop_cnt_o(drop)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event queue semantics expressed with plain arrays.
  bit            m_prev [NUM_RULES];
  bit            m_pend [NUM_RULES];
  bit            m_ovfb [NUM_RULES];
  bit [TS_W-1:0] m_ts, m_ts_rep;
  int            m_drop, m_rule;
  bit            m_busy, m_rovf, m_irq;

  task automatic model_reset();
    for (int i = 0; i < NUM_RULES; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_ovfb[i] = 0;
    end
    m_ts = 0; m_ts_rep = 0; m_drop = 0; m_rule = 0;
    m_busy = 0; m_rovf = 0; m_irq = 0;
  endtask

  task automatic model_edge();
    bit rise [NUM_RULES];
    int load;
    bit hs;
    bit any;
    hs = m_busy && ready;
    if (clear) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        m_pend[i] = 0; m_ovfb[i] = 0;
      end
      m_drop = 0;
      m_busy = 0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++)
        rise[i] = mon[i] && !m_prev[i] && mask[i] && en;
      load = -1;
      if (!m_busy)
        for (int i = NUM_RULES - 1; i >= 0; i--) if (m_pend[i]) load = i;
      for (int i = 0; i < NUM_RULES; i++)
        if (rise[i] && m_pend[i] && i != load) begin
          m_ovfb[i] = 1;
          if (m_drop < DROP_MAX) m_drop++;
        end
      if (load >= 0) begin
        m_rule = load; m_ts_rep = m_ts; m_rovf = m_ovfb[load];
        m_ovfb[load] = 0; m_busy = 1;
      end else if (hs) begin
        m_busy = 0;
      end
      for (int i = 0; i < NUM_RULES; i++)
        m_pend[i] = rise[i] || (m_pend[i] && i != load);
    end
    for (int i = 0; i < NUM_RULES; i++) m_prev[i] = mon[i];
    m_ts++;
    any = 0;
    for (int i = 0; i < NUM_RULES; i++) any |= m_pend[i];
    m_irq = m_busy || any;
  endtask

  task automatic compare_model();
    check("valid", 64'(rpt.valid), 64'(m_busy));
    check("irq", 64'(irq), 64'(m_irq));
    check("drop", 64'(drop), 64'(m_drop));
    if (m_busy) begin
      check("rule", 64'(rpt.rule), 64'(m_rule));
      check("ts", 64'(rpt.ts), 64'(m_ts_rep));
      check("ovf", 64'(rpt.ovf), 64'(m_rovf));
    end
  endtask

  // One clock: inputs are already set; model follows the edge, then compare.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_model();
  endtask

  function automatic logic [NUM_RULES-1:0] b(input int i);
    logic [NUM_RULES-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic [NUM_RULES-1:0] mon;
    logic                 exp_valid;
    logic [ID_W-1:0]      exp_rule;
    logic                 exp_irq;
  } vec_t;

  vec_t tbl [11];
  logic [TS_W-1:0] ts_a, ts_b, ts_c, ts_hold;

  initial begin
    logic [NUM_RULES-1:0] m3;
    m3 = b(5) | b(3) | b(40) | b(77);
    tbl[0]  = '{'0,    1'b0, 7'd0,  1'b0};
    tbl[1]  = '{b(5),  1'b0, 7'd0,  1'b1};
    tbl[2]  = '{b(5),  1'b1, 7'd5,  1'b1};
    tbl[3]  = '{b(5),  1'b0, 7'd0,  1'b0};
    tbl[4]  = '{m3,    1'b0, 7'd0,  1'b1};
    tbl[5]  = '{m3,    1'b1, 7'd3,  1'b1};
    tbl[6]  = '{m3,    1'b0, 7'd0,  1'b1};
    tbl[7]  = '{m3,    1'b1, 7'd40, 1'b1};
    tbl[8]  = '{m3,    1'b0, 7'd0,  1'b1};
    tbl[9]  = '{m3,    1'b1, 7'd77, 1'b1};
    tbl[10] = '{m3,    1'b0, 7'd0,  1'b0};

    rst_ni = 1'b0; mon = '0; mask = '1; en = 1'b1; clear = 1'b0; ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid", 64'(rpt.valid), 64'd0);
    check("reset_irq", 64'(irq), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    check("reset_rule", 64'(rpt.rule), 64'd0);
    check("reset_ts", 64'(rpt.ts), 64'd0);
    check("reset_ovf", 64'(rpt.ovf), 64'd0);
    #2 rst_ni = 1'b1;

    // Single rise and a three-way simultaneous rise, ready held high.
    for (int k = 0; k < 11; k++) begin
      mon = tbl[k].mon;
      step();
      check($sformatf("tbl%0d_valid", k), 64'(rpt.valid), 64'(tbl[k].exp_valid));
      check($sformatf("tbl%0d_irq", k), 64'(irq), 64'(tbl[k].exp_irq));
      if (tbl[k].exp_valid) begin
        check($sformatf("tbl%0d_rule", k), 64'(rpt.rule), 64'(tbl[k].exp_rule));
        check($sformatf("tbl%0d_ovf", k), 64'(rpt.ovf), 64'd0);
      end
      if (k == 5) ts_a = rpt.ts;
      if (k == 7) ts_b = rpt.ts;
      if (k == 9) ts_c = rpt.ts;
    end
    check("ts_gap_3_40", 64'(ts_b - ts_a), 64'd2);
    check("ts_gap_40_77", 64'(ts_c - ts_b), 64'd2);

    // Stall on rule 10 while rule 20 fires twice.
    mon = '0; step();
    ready = 1'b0; mon = b(10); step(); step();
    check("stall_rule10", 64'(rpt.rule), 64'd10);
    ts_hold = rpt.ts;
    mon = b(10) | b(20); step();
    mon = b(10); step();
    mon = b(10) | b(20); step();
    step(); step();
    check("stall_drop", 64'(drop), 64'd1);
    check("stall_rule_stable", 64'(rpt.rule), 64'd10);
    check("stall_ts_stable", 64'(rpt.ts), 64'(ts_hold));
    check("stall_valid", 64'(rpt.valid), 64'd1);
    ready = 1'b1; step();
    step();
    check("second_rule", 64'(rpt.rule), 64'd20);
    check("second_ovf", 64'(rpt.ovf), 64'd1);
    step();

    // Edges while disabled must not surface after enable.
    mon = '0; step();
    en = 1'b0; mon = b(7); step(); step();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_irq_quiet", 64'(irq), 64'd0);
      check("en_valid_quiet", 64'(rpt.valid), 64'd0);
    end
    mon = '0; step();
    mon = b(7); step(); step();
    check("en_rule7", 64'(rpt.rule), 64'd7);
    check("en_valid7", 64'(rpt.valid), 64'd1);
    step();

    // Drive the drop counter into saturation, then clear mid-SEND.
    ready = 1'b0; mon = '0; step();
    for (int k = 0; k < 900; k++) begin
      mon = '1; step();
      mon = '0; step();
    end
    check("drop_saturated", 64'(drop), 64'(DROP_MAX));
    check("sat_valid", 64'(rpt.valid), 64'd1);
    clear = 1'b1; step();
    clear = 1'b0;
    check("clear_valid", 64'(rpt.valid), 64'd0);
    check("clear_drop", 64'(drop), 64'd0);
    check("clear_irq", 64'(irq), 64'd0);
    ready = 1'b1; step();

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NUM_RULES; i++)
        if ($urandom_range(0, 15) == 0) mon[i] = ~mon[i];
      if ($urandom_range(0, 63) == 0) mask = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 63) == 0) mask = '1;
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 99) == 0);
      step();
    end
    clear = 1'b0; en = 1'b1; mask = '1;

    // Asynchronous reset while a report is held.
    mon = '0; ready = 1'b1; step(); step(); step();
    ready = 1'b0; mon = b(12); step(); step();
    check("pre_rst_valid", 64'(rpt.valid), 64'd1);
    #3 rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 64'(rpt.valid), 64'd0);
    check("async_rst_irq", 64'(irq), 64'd0);
    mon = '0; ready = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    #3 rst_ni = 1'b1;
    model_reset();
    mon = b(0); step(); step();
    check("post_rst_rule0", 64'(rpt.rule), 64'd0);
    check("post_rst_ts_small", 64'(rpt.ts < 8), 64'd1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
